// File: rtl/my_spi_master_if.sv
// Command handshake between a local controller and my_spi_master.
// The controller drives the request and the SPI master returns status and read data.
interface my_spi_master_if;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    logic              Start;
    logic              Wr;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WData;
    logic              Busy;
    logic              Done;
    logic [DATA_W-1:0] RData;

    modport master (output Start, Wr, Addr, WData, input Busy, Done, RData);
    modport slave  (input Start, Wr, Addr, WData, output Busy, Done, RData);
endinterface

// File: rtl/my_spi_master.sv
// SPI initiator for the MySPI register target.
// Each command is one 16-bit frame: {wr, addr[6:0]} then a data byte, sent MSB first.
module my_spi_master #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic             theClock,
    input  logic             theReset,
    my_spi_master_if.slave   bus,
    output logic             MySPI_clk,
    output logic             MySPI_cs,
    output logic             MySPI_sdo,
    input  logic             MySPI_sdi
);
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned FRAME_W = 16;
    localparam int unsigned TX_W    = FRAME_W - 1;
    localparam int unsigned DATA_W  = 8;

    typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_HOLD, S_GAP} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [TX_W-1:0]     tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                wr_q, wr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                sclk_q, sclk_d;
    logic                cs_q, cs_d;
    logic                sdo_q, sdo_d;
    logic                sdi_meta, sdi_sync;
    logic                div_last;

    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

    // MISO crosses from the target's clock domain
    always_ff @(posedge theClock) begin
        if (theReset) begin
            sdi_meta <= 1'b0;
            sdi_sync <= 1'b0;
        end else begin
            sdi_meta <= MySPI_sdi;
            sdi_sync <= sdi_meta;
        end
    end

    always_ff @(posedge theClock) begin
        if (theReset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            sdo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            sdo_q   <= sdo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q + DIV_W'(1);
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        sdo_d   = sdo_q;

        // the divider restarts on every state change
        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (bus.Start) begin
                    wr_d    = bus.Wr;
                    tx_d    = {bus.Addr, bus.WData};
                    sdo_d   = bus.Wr;
                    bit_d   = '0;
                    busy_d  = 1'b1;
                    cs_d    = 1'b0;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (div_last) begin
                    rx_d    = {rx_q[DATA_W-2:0], sdi_sync};
                    sclk_d  = 1'b1;
                    div_d   = '0;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (div_last) begin
                    sclk_d = 1'b0;
                    div_d  = '0;
                    if (bit_q != BIT_W'(FRAME_W - 1)) begin
                        sdo_d   = tx_q[TX_W-1];
                        tx_d    = {tx_q[TX_W-2:0], 1'b0};
                        bit_d   = bit_q + BIT_W'(1);
                        state_d = S_LOW;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // cs stays low so the target can reach its end state and commit
                if (div_last) begin
                    cs_d    = 1'b1;
                    sdo_d   = 1'b0;
                    done_d  = 1'b1;
                    if (!wr_q) rdata_d = rx_q;
                    div_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (div_last) begin
                    busy_d  = 1'b0;
                    div_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                div_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.Busy  = busy_q;
    assign bus.Done  = done_q;
    assign bus.RData = rdata_q;
    assign MySPI_clk = sclk_q;
    assign MySPI_cs  = cs_q;
    assign MySPI_sdo = sdo_q;
endmodule

// File: doc/my_spi_master.md
Name: my_spi_master

Overview:
SPI initiator that drives the off-chip/on-board MySPI register target.
- Runs one 16-bit transaction per command: an address byte (bit7 = write flag, bits6:0 = register address), then a data byte.
- Sits between a local controller (FSM or NIOS bridge) and the four SPI wires.
- Writes push a byte into a target register. Reads return the target's register value on the MISO line.

Parameters:
CLK_DIV, 8, half-period of spi_clk in theClock cycles. Legal minimum is 6, so the target's 2-flop sync and state latency fit in each phase.

Ports:
theClock  in  1  system clock, all logic on rising edge
theReset  in  1  synchronous, active-high reset
Start     in  1  one-cycle command request, honoured only when Busy=0
Wr        in  1  1=write, 0=read; sampled with Start
Addr      in  7  target register address; sampled with Start
WData     in  8  write data; sampled with Start
Busy      out 1  high from the cycle after an accepted Start until the end of the GAP phase
Done      out 1  one-cycle pulse when the transaction completes
RData     out 8  read result; valid from the Done cycle, held until the next read's Done
MySPI_clk out 1  SPI clock, idles low
MySPI_cs  out 1  chip select, active low, idles high
MySPI_sdo out 1  MOSI to target sdi
MySPI_sdi in  1  MISO from target sdo; double-synchronised internally before use

Behaviour:
- Reset values: Busy=0, Done=0, RData=0x00, MySPI_clk=0, MySPI_cs=1, MySPI_sdo=0, state=IDLE, counters=0.
- Reset mid-transfer: on the next cycle cs=1 and clk=0. The transfer is abandoned, no Done is issued, and RData keeps its reset value.
- Start with Busy=0 (cycle T):
  - Latch shift register = {Wr, Addr, WData}.
  - At T+1: Busy=1, cs=0, sdo=bit15, state=LOW.
- Start while Busy=1, including during the Done cycle, is ignored with no queueing.
- State LOW:
  - clk=0 for CLK_DIV cycles; sdo holds the current bit.
  - On the last LOW cycle, the synchronised sdi is shifted into the receive register (sample point = just before the rising edge). Then go to HIGH.
- State HIGH:
  - clk=1 for CLK_DIV cycles.
  - On exit, clk falls. If bit counter < 15: shift TX so the next bit appears on sdo with the falling edge, increment the counter, go to LOW. Otherwise go to HOLD.
- State HOLD: clk=0, cs=0 for CLK_DIV cycles. This lets the target reach its end state and commit the write.
- On HOLD exit:
  - cs=1, sdo=0, Done=1 for exactly that cycle.
  - If the latched Wr=0, RData = received byte (bits 7:0 of the 16 samples, i.e. the last 8). If Wr=1, RData is unchanged.
  - Then go to GAP.
- State GAP: cs=1 for CLK_DIV cycles, then IDLE with Busy=0.
- Timing summary:
  - cs low for exactly 33*CLK_DIV cycles.
  - 16 rising clk edges per transaction.
  - Busy high for 34*CLK_DIV cycles.
- Bit order: MSB first. MOSI sequence = {Wr, Addr[6:0], WData[7:0]}. For reads, WData is transmitted as given, and the target ignores it.
- Bit counter 4 bits, 0..15, no wrap during a transaction. The divider counter resets on every state change.

Test Plan:
- Write: CLK_DIV=8, Start Wr=1 Addr=0x03 WData=0xA5 → MOSI bits at 16 rising edges = 0x83 then 0xA5; cs low 264 cycles; Done 1 cycle; paired MySPI target shows Red=0xA5; RData stays 0x00.
- Read: target Status=0x5C, Start Wr=0 Addr=0x01 → MOSI first byte 0x01; RData=0x5C on the Done cycle; Busy low 272 cycles after the Start cycle +1.
- Back-to-back: write Led70=0x3C, then read Led70 on the first cycle Busy=0 → RData=0x3C; cs high ≥ CLK_DIV cycles between transactions.
- Start pulses during Busy and on the Done cycle → ignored; exactly one transaction observed, with 16 clk edges.
- theReset asserted at bit 9 of a write to Blue → next cycle cs=1, clk=0, no Done; target Trigger never pulses; next Start runs normally.
- CLK_DIV=6 read of Config after a write of 0x81 → RData=0x81; clk high/low phases exactly 6 cycles each.
